traffic_light_ctrl: RTL and testbench



---
 rtl/traffic_light_ctrl.sv | 179 +++++++++++++++++
 tb/tb_traffic_light_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: timed two-approach intersection controller.
// Sequences NS/EW heads through green, yellow and all-red clearance,
// with a fault-driven flashing-yellow mode. Lamp outputs are registered
// so they change only on the clock edge that updates the state.
// Optional feature macro: TL_PED_EN enables the latched pedestrian walk phase.
module traffic_light_ctrl #(
  parameter int CNT_W       = 8,
  parameter int GREEN_CYC   = 16,
  parameter int YELLOW_CYC  = 4,
  parameter int ALL_RED_CYC = 2,
  parameter int PED_CYC     = 8,
  parameter int FLASH_CYC   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ped_req,
  input  logic       fault,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    ALL_RED_B = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    ALL_RED_A = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    PED_WALK  = 3'd6,
    FLASH     = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] LD_FLASH = CNT_W'(FLASH_CYC - 1);

  // Lamp vector order: {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}
  localparam logic [5:0] LAMPS_ALL_RED = 6'b100_100;

  state_t           state, state_nx;
  logic [CNT_W-1:0] timer, timer_nx;
  logic             flash, flash_nx;
  logic             ped_go;
  logic [5:0]       lamps, lamps_nx;

  // Timer reload value (duration - 1) for the phase being entered.
  function automatic logic [CNT_W-1:0] dur_m1(input state_t s);
    logic [CNT_W-1:0] d;
    case (s)
      NS_GREEN, EW_GREEN:   d = CNT_W'(GREEN_CYC - 1);
      NS_YELLOW, EW_YELLOW: d = CNT_W'(YELLOW_CYC - 1);
      PED_WALK:             d = CNT_W'(PED_CYC - 1);
      FLASH:                d = CNT_W'(FLASH_CYC - 1);
      default:              d = CNT_W'(ALL_RED_CYC - 1);
    endcase
    return d;
  endfunction

  // Lamp decode of a state; in FLASH only the yellows are lit, following the flash bit.
  function automatic logic [5:0] lamp_decode(input state_t s, input logic fl);
    logic [5:0] l;
    case (s)
      NS_GREEN:  l = 6'b001_100;
      NS_YELLOW: l = 6'b010_100;
      EW_GREEN:  l = 6'b100_001;
      EW_YELLOW: l = 6'b100_010;
      FLASH:     l = {1'b0, fl, 1'b0, 1'b0, fl, 1'b0};
      default:   l = LAMPS_ALL_RED;
    endcase
    return l;
  endfunction

  // Next-state, timer and flash-bit logic; fault has priority over timer expiry.
  always_comb begin
    state_nx = state;
    timer_nx = timer;
    flash_nx = flash;
    if (fault) begin
      if (state != FLASH) begin
        state_nx = FLASH;
        timer_nx = LD_FLASH;
        flash_nx = 1'b0;
      end else if (tick) begin
        if (timer == '0) begin
          flash_nx = ~flash;
          timer_nx = LD_FLASH;
        end else begin
          timer_nx = timer - ONE;
        end
      end
    end else if (state == FLASH) begin
      // Fault released: restart from a full all-red clearance.
      state_nx = ALL_RED_B;
      timer_nx = dur_m1(ALL_RED_B);
      flash_nx = 1'b0;
    end else if (tick) begin
      if (timer != '0) begin
        timer_nx = timer - ONE;
      end else begin
        case (state)
          ALL_RED_B: state_nx = NS_GREEN;
          NS_GREEN:  state_nx = NS_YELLOW;
          NS_YELLOW: state_nx = ALL_RED_A;
          ALL_RED_A: state_nx = EW_GREEN;
          EW_GREEN:  state_nx = EW_YELLOW;
          EW_YELLOW: state_nx = ped_go ? PED_WALK : ALL_RED_B;
          default:   state_nx = ALL_RED_B;
        endcase
        timer_nx = dur_m1(state_nx);
      end
    end
  end

  // State, timer and flash-bit registers; reset wins over fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ALL_RED_B;
      timer <= dur_m1(ALL_RED_B);
      flash <= 1'b0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
      flash <= flash_nx;
    end
  end

  assign lamps_nx = lamp_decode(state_nx, flash_nx);

  // Registered lamp drivers, updated on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) lamps <= LAMPS_ALL_RED;
    else     lamps <= lamps_nx;
  end

  assign {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green} = lamps;
  assign phase = state;

`ifdef TL_PED_EN
  logic pend, pend_nx, walk_q;

  assign ped_go = pend;

  // Request latch: cleared on PED_WALK entry, where a same-cycle request is dropped.
  always_comb begin
    pend_nx = pend;
    if (state_nx == PED_WALK && state != PED_WALK) pend_nx = 1'b0;
    else if (ped_req)                              pend_nx = 1'b1;
  end

  // Pending-request and walk-lamp registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend   <= 1'b0;
      walk_q <= 1'b0;
    end else begin
      pend   <= pend_nx;
      walk_q <= (state_nx == PED_WALK);
    end
  end

  assign ped_pending = pend;
  assign walk        = walk_q;
`else
  logic unused_ped_req;

  assign unused_ped_req = ped_req;
  assign ped_go         = 1'b0;
  assign ped_pending    = 1'b0;
  assign walk           = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench for traffic_light_ctrl: the driver pushes the hand-computed
// expected phase/flash/pending after each edge, a negedge monitor pops and compares.
module tb_traffic_light_ctrl;

  logic       clk = 1'b0;
  logic       rst, tick, ped_req, fault;
  logic       ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green;
  logic       walk, ped_pending;
  logic [2:0] phase;

  typedef struct packed {
    logic [2:0] ph;
    logic       fy;
    logic       pend;
  } exp_t;

  exp_t expq[$];
  int   checks   = 0;
  int   failures = 0;

  // Phase per tick after reset, period 12 (GREEN=3, YELLOW=2, ALL_RED=1).
  logic [2:0] pat [12] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2,
                           3'd3, 3'd4, 3'd4, 3'd4, 3'd5, 3'd5};

  traffic_light_ctrl #(
    .CNT_W(8), .GREEN_CYC(3), .YELLOW_CYC(2), .ALL_RED_CYC(1),
    .PED_CYC(2), .FLASH_CYC(2)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .ped_req(ped_req), .fault(fault),
    .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
    .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
    .walk(walk), .ped_pending(ped_pending), .phase(phase)
  );

  always #5 clk = ~clk;

  // Expected {ns_r,ns_y,ns_g,ew_r,ew_y,ew_g,walk} for a phase and flash bit.
  function automatic logic [6:0] exp_lamps(input logic [2:0] ph, input logic fy);
    logic [6:0] l;
    case (ph)
      3'd1:    l = 7'b001_100_0;
      3'd2:    l = 7'b010_100_0;
      3'd4:    l = 7'b100_001_0;
      3'd5:    l = 7'b100_010_0;
      3'd6:    l = 7'b100_100_1;
      3'd7:    l = {1'b0, fy, 1'b0, 1'b0, fy, 1'b0, 1'b0};
      default: l = 7'b100_100_0;
    endcase
    return l;
  endfunction

  // Monitor: compare presented outputs against the scoreboard, and check safety.
  always @(negedge clk) begin
    exp_t       e;
    logic [6:0] act, req;
    checks++;
    if ((ns_green === 1'b1 && (ew_green === 1'b1 || ew_yellow === 1'b1)) ||
        (ew_green === 1'b1 && (ns_green === 1'b1 || ns_yellow === 1'b1))) begin
      failures++;
      $display("FAIL safety t=%0t ns_g=%b ew_g=%b ew_y=%b ns_y=%b", $time,
               ns_green, ew_green, ew_yellow, ns_yellow);
    end
    if (expq.size() > 0) begin
      e   = expq.pop_front();
      act = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk};
      req = exp_lamps(e.ph, e.fy);
      checks++;
      if (phase !== e.ph) begin
        failures++;
        $display("FAIL phase t=%0t got=%0d want=%0d", $time, phase, e.ph);
      end
      checks++;
      if (act !== req) begin
        failures++;
        $display("FAIL lamps t=%0t got=%b want=%b (phase want %0d)", $time, act, req, e.ph);
      end
      checks++;
      if (ped_pending !== e.pend) begin
        failures++;
        $display("FAIL ped_pending t=%0t got=%b want=%b", $time, ped_pending, e.pend);
      end
    end
  end

  // Drive inputs for one edge, then queue the outputs expected after it.
  task automatic step(input logic r, input logic t, input logic p, input logic f,
                      input logic [2:0] ph, input logic fy, input logic pd);
    rst = r; tick = t; ped_req = p; fault = f;
    @(posedge clk);
    #1;
    expq.push_back({ph, fy, pd});
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [8:0] fyt;
    int         guard;
    rst = 1'b0; tick = 1'b0; ped_req = 1'b0; fault = 1'b0;
    fyt = 9'b011001100;

    // Free-running sequence with tick tied high.
    do_reset();
    for (int i = 1; i <= 24; i++) step(1'b0, 1'b1, 1'b0, 1'b0, pat[i % 12], 1'b0, 1'b0);

    // Tick only every third clock: state holds between ticks.
    do_reset();
    for (int k = 0; k < 36; k++)
      step(1'b0, (k % 3 == 2), 1'b0, 1'b0, pat[((k + 1) / 3) % 12], 1'b0, 1'b0);

`ifdef TL_PED_EN
    // Pedestrian request during NS_GREEN, served after EW_YELLOW.
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 1'b1);
    for (int i = 3; i <= 11; i++) step(1'b0, 1'b1, 1'b0, 1'b0, pat[i], 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 3'd6, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 3'd6, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
`else
    // Request held high is ignored; sequence unchanged.
    do_reset();
    for (int i = 1; i <= 24; i++) step(1'b0, 1'b1, 1'b1, 1'b0, pat[i % 12], 1'b0, 1'b0);
`endif

    // Fault during EW_GREEN for 9 clocks, then release.
    do_reset();
    for (int i = 1; i <= 7; i++) step(1'b0, 1'b1, 1'b0, 1'b0, pat[i], 1'b0, 1'b0);
    for (int j = 0; j < 9; j++) step(1'b0, 1'b1, 1'b0, 1'b1, 3'd7, fyt[j], 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);

    // Reset during NS_YELLOW with fault high: reset wins.
    do_reset();
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, pat[i], 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);

    guard = 0;
    while (expq.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
